// File: rtl/layered_priority_mux.sv
// layered_priority_mux: N-layer pixel compositor with a two-stage pipeline
// and per-frame sticky collision flags.
// Layer 0 has the highest priority. The background colour is used when no layer wins.
// Optional macro LAYER_TRANSP_KEY_EN: a layer pixel whose colour equals TRANSP_RGB is
// treated as transparent. It falls through to the lower layers and never collides.
// Advance rule: pixel_en is a one-way strobe with no back-pressure. A cycle with
// pixel_en=1 moves every stage forward by one pixel. A cycle with pixel_en=0 freezes
// every register, so the outputs stay stable.
module layered_priority_mux #(
    parameter int               NUM_LAYERS = 8,
    parameter int               RGB_W      = 8,
    parameter logic [RGB_W-1:0] TRANSP_RGB = 8'hFF
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          pixel_en,
    input  logic                          start_of_frame,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         layer_DR,
    input  logic [NUM_LAYERS*RGB_W-1:0]   layer_RGB,
    input  logic [RGB_W-1:0]              background_RGB,
    output logic [RGB_W-1:0]              RGBOut,
    output logic [$clog2(NUM_LAYERS)-1:0] winner_idx,
    output logic                          winner_valid,
    output logic                          collision_pulse,
    output logic [NUM_LAYERS-1:0]         collision_frame
);

    localparam int IDX_W = $clog2(NUM_LAYERS);

`ifdef LAYER_TRANSP_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    // Combinational priority resolution
    logic [NUM_LAYERS-1:0] eff_c;
    logic [IDX_W-1:0]      win_idx_c;
    logic [RGB_W-1:0]      win_rgb_c;
    logic                  any_c;
    logic [1:0]            cnt_c;
    logic                  multi_c;

    // Stage 1 registers
    logic [IDX_W-1:0]      s1_idx_q;
    logic [RGB_W-1:0]      s1_rgb_q;
    logic                  s1_any_q;
    logic                  s1_multi_q;
    logic [NUM_LAYERS-1:0] s1_eff_q;
    logic                  s1_sof_q;

    // Stage 2 registers, which also hold the collision accumulator
    logic [RGB_W-1:0]      rgb_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  valid_q;
    logic                  pulse_q;
    logic [NUM_LAYERS-1:0] acc_q;
    logic [NUM_LAYERS-1:0] acc_d;
    logic [NUM_LAYERS-1:0] frame_q;
    logic [NUM_LAYERS-1:0] frame_d;
    logic [NUM_LAYERS-1:0] coll_bits;

    // Effective requests, the lowest-index winner and a saturating count of requests
    always_comb begin
        eff_c     = '0;
        win_idx_c = '0;
        win_rgb_c = background_RGB;
        cnt_c     = 2'd0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_c[i] = layer_en[i] & layer_DR[i] &
                       ~(KEY_EN && (layer_RGB[i*RGB_W +: RGB_W] == TRANSP_RGB));
        end
        // Scan from the lowest priority upward so that the lowest index wins.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_c[i]) begin
                win_idx_c = IDX_W'(i);
                win_rgb_c = layer_RGB[i*RGB_W +: RGB_W];
            end
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (eff_c[i] && cnt_c != 2'd2) cnt_c = cnt_c + 2'd1;
        end
        any_c   = |eff_c;
        multi_c = (cnt_c == 2'd2);
    end

    // Stage 1: capture the resolved pixel and its side-band bits
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_idx_q   <= '0;
            s1_rgb_q   <= '0;
            s1_any_q   <= 1'b0;
            s1_multi_q <= 1'b0;
            s1_eff_q   <= '0;
            s1_sof_q   <= 1'b0;
        end else if (pixel_en) begin
            s1_idx_q   <= win_idx_c;
            s1_rgb_q   <= win_rgb_c;
            s1_any_q   <= any_c;
            s1_multi_q <= multi_c;
            s1_eff_q   <= eff_c;
            s1_sof_q   <= start_of_frame;
        end
    end

    // Frame bookkeeping: the SOF pixel publishes the accumulator and then restarts it
    // with only its own collision bits.
    always_comb begin
        coll_bits = s1_multi_q ? s1_eff_q : '0;
        frame_d   = frame_q;
        acc_d     = acc_q | coll_bits;
        if (s1_sof_q) begin
            frame_d = acc_q;
            acc_d   = coll_bits;
        end
    end

    // Stage 2: drive the outputs and update the collision flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            acc_q   <= '0;
            frame_q <= '0;
        end else if (pixel_en) begin
            rgb_q   <= s1_rgb_q;
            idx_q   <= s1_any_q ? s1_idx_q : '0;
            valid_q <= s1_any_q;
            pulse_q <= s1_multi_q;
            acc_q   <= acc_d;
            frame_q <= frame_d;
        end
    end

    assign RGBOut          = rgb_q;
    assign winner_idx      = idx_q;
    assign winner_valid    = valid_q;
    assign collision_pulse = pulse_q;
    assign collision_frame = frame_q;

endmodule

// File: tb/tb_layered_priority_mux.sv
// Bench for layered_priority_mux with NUM_LAYERS=8 and RGB_W=8.
// It combines a vector table, hand-written frame, stall and reset sequences, and
// randomized traffic scored against a pixel-level reference model.
module tb_layered_priority_mux;

    localparam int N = 8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           resetN;
    logic           pixel_en;
    logic           sof;
    logic [N-1:0]   layer_en;
    logic [N-1:0]   layer_DR;
    logic [N*W-1:0] layer_RGB;
    logic [W-1:0]   background_RGB;
    logic [W-1:0]   RGBOut;
    logic [2:0]     winner_idx;
    logic           winner_valid;
    logic           collision_pulse;
    logic [N-1:0]   collision_frame;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] rgb;
        logic [2:0]   idx;
        logic         valid;
        logic         pulse;
        logic         sof;
        logic [N-1:0] bits;
    } exp_t;

    typedef struct {
        logic [N-1:0]   en;
        logic [N-1:0]   dr;
        logic [N*W-1:0] rgb;
        logic [W-1:0]   bg;
        logic [W-1:0]   e_rgb;
        logic [2:0]     e_idx;
        logic           e_valid;
        logic           e_pulse;
    } vec_t;

    exp_t         exp_q[$];
    exp_t         cur;
    logic [N-1:0] m_acc;
    logic [N-1:0] m_frame;
    vec_t         vecs[6];

    localparam logic [N*W-1:0] BASE_RGB = 64'h1010101010101010;

    layered_priority_mux #(.NUM_LAYERS(N), .RGB_W(W), .TRANSP_RGB(8'hFF)) dut (
        .clk(clk), .resetN(resetN), .pixel_en(pixel_en), .start_of_frame(sof),
        .layer_en(layer_en), .layer_DR(layer_DR), .layer_RGB(layer_RGB),
        .background_RGB(background_RGB), .RGBOut(RGBOut), .winner_idx(winner_idx),
        .winner_valid(winner_valid), .collision_pulse(collision_pulse),
        .collision_frame(collision_frame)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference pixel: the top-most enabled drawing layer wins, and two or more drawing layers collide.
    function automatic exp_t model(input logic [N-1:0] en, input logic [N-1:0] dr,
                                   input logic [N*W-1:0] rgb, input logic [W-1:0] bg,
                                   input logic s);
        exp_t         e;
        int           n;
        logic [N-1:0] eff;
        e     = '0;
        e.rgb = bg;
        n     = 0;
        for (int i = 0; i < N; i++) begin
            eff[i] = en[i] & dr[i];
`ifdef LAYER_TRANSP_KEY_EN
            if (rgb[i*W +: W] == 8'hFF) eff[i] = 1'b0;
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (eff[i]) begin
                n++;
                if (!e.valid) begin
                    e.valid = 1'b1;
                    e.idx   = 3'(i);
                    e.rgb   = rgb[i*W +: W];
                end
            end
        end
        e.pulse = (n >= 2);
        e.bits  = e.pulse ? eff : '0;
        e.sof   = s;
        return e;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        cur     = '0;
        m_acc   = '0;
        m_frame = '0;
    endtask

    // One clock. An advancing cycle queues the expected pixel, which appears two advances later.
    task automatic step(input logic pe);
        pixel_en = pe;
        if (pe) exp_q.push_back(model(layer_en, layer_DR, layer_RGB, background_RGB, sof));
        @(posedge clk);
        #1;
        if (pe && exp_q.size() >= 2) begin
            cur = exp_q.pop_front();
            if (cur.sof) begin
                m_frame = m_acc;
                m_acc   = cur.bits;
            end else begin
                m_acc = m_acc | cur.bits;
            end
        end
        chk("sb_rgb", RGBOut, cur.rgb);
        chk("sb_idx", winner_idx, cur.idx);
        chk("sb_valid", winner_valid, cur.valid);
        chk("sb_pulse", collision_pulse, cur.pulse);
        chk("sb_frame", collision_frame, m_frame);
    endtask

    task automatic pix(input logic s, input logic [N-1:0] dr);
        sof      = s;
        layer_DR = dr;
        step(1'b1);
        sof = 1'b0;
    endtask

    task automatic rand_inputs();
        layer_DR       = N'($urandom) & N'($urandom);
        layer_en       = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
        background_RGB = W'($urandom);
        for (int i = 0; i < N; i++)
            layer_RGB[i*W +: W] = ($urandom_range(0, 5) == 0) ? 8'hFF : W'($urandom);
        sof = ($urandom_range(0, 39) == 0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        chk("rst_rgb", RGBOut, 8'h00);
        chk("rst_idx", winner_idx, 3'd0);
        chk("rst_valid", winner_valid, 1'b0);
        chk("rst_pulse", collision_pulse, 1'b0);
        chk("rst_frame", collision_frame, 8'h00);
        clear_model();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        resetN         = 1'b0;
        pixel_en       = 1'b0;
        sof            = 1'b0;
        layer_en       = 8'hFF;
        layer_DR       = 8'h00;
        layer_RGB      = BASE_RGB;
        background_RGB = 8'h00;
        clear_model();

        vecs[0] = '{8'hFF, 8'b0010_0100, 64'h10105510101C1010, 8'h00, 8'h1C, 3'd2, 1'b1, 1'b1};
        vecs[1] = '{8'hFB, 8'h04, BASE_RGB, 8'h03, 8'h03, 3'd0, 1'b0, 1'b0};
`ifdef LAYER_TRANSP_KEY_EN
        vecs[2] = '{8'hFF, 8'h03, 64'h10101010101042FF, 8'h00, 8'h42, 3'd1, 1'b1, 1'b0};
`else
        vecs[2] = '{8'hFF, 8'h03, 64'h10101010101042FF, 8'h00, 8'hFF, 3'd0, 1'b1, 1'b1};
`endif
        vecs[3] = '{8'hFF, 8'h00, BASE_RGB, 8'hA5, 8'hA5, 3'd0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'h80, 64'h3310101010101010, 8'h00, 8'h33, 3'd7, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 64'h1010101010101011, 8'h00, 8'h11, 3'd0, 1'b1, 1'b1};

        // Power-on reset state
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Vector table: hold each input for two advances, then compare.
        foreach (vecs[k]) begin
            layer_en       = vecs[k].en;
            layer_DR       = vecs[k].dr;
            layer_RGB      = vecs[k].rgb;
            background_RGB = vecs[k].bg;
            step(1'b1);
            step(1'b1);
            chk($sformatf("vec%0d_rgb", k), RGBOut, vecs[k].e_rgb);
            chk($sformatf("vec%0d_idx", k), winner_idx, vecs[k].e_idx);
            chk($sformatf("vec%0d_valid", k), winner_valid, vecs[k].e_valid);
            chk($sformatf("vec%0d_pulse", k), collision_pulse, vecs[k].e_pulse);
        end

        // Frame flags: frame A overlaps layers 1 and 3, and frame B has no overlaps.
        do_reset();
        layer_en       = 8'hFF;
        layer_RGB      = BASE_RGB;
        background_RGB = 8'h07;
        pix(1'b1, 8'h00);
        pix(1'b0, 8'h0A);
        pix(1'b0, 8'h02);
        pix(1'b0, 8'h10);
        pix(1'b1, 8'h00);
        pix(1'b0, 8'h01);
        pix(1'b0, 8'h04);
        pix(1'b0, 8'h00);
        pix(1'b0, 8'h00);
        chk("frame_b_flags", collision_frame, 8'b0000_1010);
        pix(1'b1, 8'h00);
        pix(1'b0, 8'h00);
        pix(1'b0, 8'h00);
        chk("frame_c_flags", collision_frame, 8'h00);

        // Stall: inputs change while pixel_en=0, and then the pipeline resumes.
        pix(1'b0, 8'h06);
        pix(1'b0, 8'h30);
        for (int c = 0; c < 5; c++) begin
            rand_inputs();
            sof = 1'b0;
            step(1'b0);
        end
        layer_en  = 8'hFF;
        layer_RGB = BASE_RGB;
        pix(1'b0, 8'h00);
        pix(1'b1, 8'h00);
        pix(1'b0, 8'h00);
        pix(1'b0, 8'h00);
        chk("stall_frame_flags", collision_frame, 8'b0011_0110);

        // Reset mid-stream with layers drawing. The first valid output appears after two advances.
        layer_DR = 8'hFF;
        pix(1'b0, 8'hFF);
        do_reset();
        layer_RGB = BASE_RGB;
        pix(1'b0, 8'h0C);
        chk("post_rst_lat1_valid", winner_valid, 1'b0);
        pix(1'b0, 8'h0C);
        chk("post_rst_lat2_valid", winner_valid, 1'b1);
        chk("post_rst_lat2_idx", winner_idx, 3'd2);

        // Randomized traffic with stalls and one reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            if (c == 700) do_reset();
            step($urandom_range(0, 3) != 0);
        end
        sof      = 1'b0;
        layer_DR = 8'h00;
        pix(1'b1, 8'h00);
        pix(1'b0, 8'h00);
        pix(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
